// File: rtl/csr_rec_packer_pkg.sv
// Shared types for the CSR record packer: the 256-bit record layout, the
// commit slot index, and the ring-occupancy helper.
package csr_rec_pkg;

  typedef struct packed {
    logic [63:0] w3;
    logic [63:0] w2;
    logic [63:0] w1;
    logic [63:0] w0;
  } rec_t;

  localparam logic [1:0] COMMIT_IDX = 2'd3;

  localparam int unsigned OFF_W = 64;
  typedef logic [OFF_W-1:0] off_t;

  function automatic off_t ring_used(input off_t head, input off_t tail, input off_t capacity);
    return (head >= tail) ? head - tail : head + capacity - tail;
  endfunction

endpackage

// File: rtl/csr_rec_packer_fifo.sv
// DEPTH-entry synchronous record FIFO with synchronous clear; a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module csr_rec_fifo
  import csr_rec_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  rec_t                     i_wr_data,
  output rec_t                     o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  rec_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rptr];
  assign w_pop     = i_pop && !o_empty;
  assign w_push    = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clr) r_mem[r_wptr] <= i_wr_data;
  end

endmodule

// File: rtl/csr_rec_packer.sv
// Packs 64-bit CSR writes into 256-bit records and issues them to the host-buffer
// writer while the ring has space. Optional build macro: CSR_REC_PACK_TSTAMP_EN.
module csr_rec_packer
  import csr_rec_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     csr_wr_valid,
  input  logic [1:0]               csr_wr_idx,
  input  logic [63:0]              csr_wr_data,
  input  logic                     flush,
  input  logic                     tx_full,
  input  logic [CW-1:0]            capacity,
  input  logic [CW-1:0]            tail,
  output logic                     new_go,
  output logic [255:0]             data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     ring_full,
  output logic [31:0]              drop_cnt,
  output logic                     overflow
);

  logic [63:0]   r_w0;
  logic [63:0]   r_w1;
  logic [63:0]   r_w2;
  logic [CW-1:0] r_head;
  logic          r_new_go;
  rec_t          r_data;
  logic [31:0]   r_drop_cnt;
  logic          r_overflow;

  logic          w_commit;
  logic          w_issue;
  logic          w_push;
  logic          w_drop;
  logic          w_full;
  logic          w_empty;
  logic          w_ring_full;
  logic [63:0]   w_w0;
  off_t          w_used;
  rec_t          w_rec;
  rec_t          w_rd_data;

`ifdef CSR_REC_PACK_TSTAMP_EN
  logic [63:0]   r_cyc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cyc <= '0;
    else     r_cyc <= r_cyc + 1'b1;
  end

  assign w_w0 = r_cyc;
`else
  assign w_w0 = r_w0;
`endif

  // One ring slot always stays empty, so full is reached at used == capacity-1.
  assign w_used      = ring_used(off_t'(r_head), off_t'(tail), off_t'(capacity));
  assign w_ring_full = (capacity < CW'(2)) || (w_used >= off_t'(capacity) - 1'b1);

  assign w_commit = csr_wr_valid && (csr_wr_idx == COMMIT_IDX) && !flush;
  assign w_issue  = !w_empty && !tx_full && !w_ring_full && !flush;
  assign w_push   = w_commit && (!w_full || w_issue);
  assign w_drop   = w_commit && w_full && !w_issue;
  assign w_rec    = '{w3: csr_wr_data, w2: r_w2, w1: r_w1, w0: w_w0};

  csr_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (flush),
    .i_push    (w_push),
    .i_pop     (w_issue),
    .i_wr_data (w_rec),
    .o_rd_data (w_rd_data),
    .o_count   (fifo_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w0 <= '0;
      r_w1 <= '0;
      r_w2 <= '0;
    end else if (csr_wr_valid) begin
      case (csr_wr_idx)
        2'd0:    r_w0 <= csr_wr_data;
        2'd1:    r_w1 <= csr_wr_data;
        2'd2:    r_w2 <= csr_wr_data;
        default: ;
      endcase
    end
  end

  // Head mirror follows the writer's offset update; a head left beyond a
  // shrunken capacity wraps to 0 on the next pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head   <= '0;
      r_new_go <= 1'b0;
      r_data   <= '0;
    end else begin
      r_new_go <= w_issue;
      if (flush) begin
        r_head <= '0;
      end else if (w_issue) begin
        r_head <= (r_head < capacity - 1'b1) ? r_head + 1'b1 : '0;
        r_data <= w_rd_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign new_go    = r_new_go;
  assign data      = r_data;
  assign ring_full = w_ring_full;
  assign drop_cnt  = r_drop_cnt;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_csr_rec_packer.sv
// Scoreboard bench for csr_rec_packer: a queue-based reference model predicts
// issued records and status; a monitor checks every new_go against it.
module tb_csr_rec_packer;

  localparam int DEPTH = 8;
  localparam int CW    = 64;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   csr_wr_valid = 1'b0;
  logic [1:0]             csr_wr_idx = '0;
  logic [63:0]            csr_wr_data = '0;
  logic                   flush = 1'b0;
  logic                   tx_full = 1'b0;
  logic [CW-1:0]          capacity = 64'd16;
  logic [CW-1:0]          tail = '0;
  logic                   new_go;
  logic [255:0]           data;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   ring_full;
  logic [31:0]            drop_cnt;
  logic                   overflow;

  csr_rec_packer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .csr_wr_valid (csr_wr_valid),
    .csr_wr_idx   (csr_wr_idx),
    .csr_wr_data  (csr_wr_data),
    .flush        (flush),
    .tx_full      (tx_full),
    .capacity     (capacity),
    .tail         (tail),
    .new_go       (new_go),
    .data         (data),
    .fifo_count   (fifo_count),
    .ring_full    (ring_full),
    .drop_cnt     (drop_cnt),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] rec;
    int           due;
  } exp_t;

  exp_t         sb[$];
  logic [255:0] mq[$];
  logic [63:0]  m_st [3];
  logic [63:0]  m_head;
  logic [63:0]  m_cyc;
  logic [31:0]  m_drop;
  logic         m_ovf;
  int           cyc;
  int           n_chk;
  int           n_fail;
  bit           m_iss;
  logic [63:0]  m_w0;
  exp_t         e_mon;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_ring_full(input logic [63:0] h, input logic [63:0] t, input logic [63:0] c);
    logic [64:0] used;
    if (c < 2) return 1'b1;
    used = (h >= t) ? {1'b0, h} - {1'b0, t} : {1'b0, h} + {1'b0, c} - {1'b0, t};
    return (used + 1) >= {1'b0, c};
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) m_cyc = '0;
    else     m_cyc = m_cyc + 1;
  end

  // Reference model: registers as seen during the current cycle, then the next state.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      sb.delete();
      m_head = '0;
      m_drop = '0;
      m_ovf  = 1'b0;
      for (int i = 0; i < 3; i++) m_st[i] = '0;
    end else begin
      chk("fifo_count", fifo_count, mq.size());
      chk("drop_cnt", drop_cnt, m_drop);
      chk("overflow", overflow, m_ovf);
      chk("head", dut.r_head, m_head);
      chk("ring_full", ring_full, m_ring_full(m_head, tail, capacity));
      m_iss = (mq.size() > 0) && !tx_full && !m_ring_full(m_head, tail, capacity) && !flush;
      if (m_iss) begin
        sb.push_back('{mq.pop_front(), cyc + 1});
        m_head = ({1'b0, m_head} + 1 < {1'b0, capacity}) ? m_head + 1 : '0;
      end
      if (csr_wr_valid) begin
        if (csr_wr_idx == 2'd3) begin
          if (!flush) begin
`ifdef CSR_REC_PACK_TSTAMP_EN
            m_w0 = m_cyc;
`else
            m_w0 = m_st[0];
`endif
            if (mq.size() == DEPTH) begin
              m_ovf = 1'b1;
              if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
            end else begin
              mq.push_back({csr_wr_data, m_st[2], m_st[1], m_w0});
            end
          end
        end else begin
          m_st[csr_wr_idx] = csr_wr_data;
        end
      end
      if (flush) begin
        mq.delete();
        m_head = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (new_go) begin
        if (sb.size() == 0) begin
          chk("spurious_new_go", new_go, 1'b0);
        end else begin
          e_mon = sb.pop_front();
          chk("issue_data", data, e_mon.rec);
          chk("issue_cycle", cyc, e_mon.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e_mon = sb.pop_front();
        chk("missed_new_go", new_go, 1'b1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [63:0] d);
    csr_wr_valid = 1'b1;
    csr_wr_idx   = idx;
    csr_wr_data  = d;
    step(1);
    csr_wr_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    #12;
    chk("rst_new_go", new_go, 1'b0);
    chk("rst_data", data, '0);
    chk("rst_fifo_count", fifo_count, '0);
    chk("rst_drop_cnt", drop_cnt, '0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_ring_full", ring_full, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic record with known words.
    wr(2'd0, 64'd1); wr(2'd1, 64'd2); wr(2'd2, 64'd3); wr(2'd3, 64'd4);
    step(4);

    // Small ring: three issue, two wait for the tail to advance.
    do_flush();
    capacity = 64'd4;
    tail     = '0;
    for (int i = 0; i < 5; i++) wr(2'd3, rnd64());
    step(6);
    tail = 64'd2;
    step(6);

    // Overflow with writer backpressure, then drain back-to-back.
    do_flush();
    capacity = 64'd16;
    tail     = '0;
    tx_full  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) wr(2'(i % 3), rnd64());
      wr(2'd3, rnd64());
    end
    tx_full = 1'b0;
    step(12);

    // Toggling backpressure.
    do_flush();
    tx_full = 1'b1;
    for (int i = 0; i < 4; i++) wr(2'd3, rnd64());
    for (int i = 0; i < 12; i++) begin
      tx_full = ~tx_full;
      step(1);
    end
    tx_full = 1'b0;
    step(4);

    // Flush with a same-cycle commit.
    tx_full = 1'b1;
    for (int i = 0; i < 3; i++) wr(2'd3, rnd64());
    flush        = 1'b1;
    csr_wr_valid = 1'b1;
    csr_wr_idx   = 2'd3;
    csr_wr_data  = rnd64();
    step(1);
    flush        = 1'b0;
    csr_wr_valid = 1'b0;
    tx_full      = 1'b0;
    step(5);

    // Randomized traffic on an 8-entry ring with a moving tail.
    capacity = 64'd8;
    tail     = '0;
    do_flush();
    for (int i = 0; i < 400; i++) begin
      csr_wr_valid = ($urandom_range(0, 2) != 0);
      csr_wr_idx   = 2'($urandom_range(0, 3));
      csr_wr_data  = rnd64();
      tx_full      = ($urandom_range(0, 3) == 0);
      flush        = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) tail = m_head;
      step(1);
    end
    csr_wr_valid = 1'b0;
    flush        = 1'b0;
    tx_full      = 1'b0;
    tail         = m_head;
    step(12);

    // Asynchronous reset while records are being issued.
    tx_full = 1'b1;
    for (int i = 0; i < 3; i++) wr(2'd3, rnd64());
    tx_full = 1'b0;
    step(1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_new_go", new_go, 1'b0);
    chk("async_rst_fifo_count", fifo_count, '0);
    @(posedge clk); #1;
    rst  = 1'b0;
    tail = '0;
    wr(2'd0, rnd64()); wr(2'd3, rnd64());
    step(6);

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
